wb_bitmap_loader: RTL and testbench

Writeback-end unit of the CPU pipeline that drives the register-file write ports of the decode stage. Scalar results are registered and presented on `write_reg_*`. LDB instructions are sequenced as 96 consecutive 16-bit data-memory reads assembled into one 1536-bit bitmap, then committed through `write_bm_*` in a single cycle, with the pipeline stalled for the duration.

---
 rtl/wb_bitmap_loader.sv | 140 ++++++++++++++
 tb/tb_wb_bitmap_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bitmap_loader.sv
// Writeback-end unit: registers scalar results onto the register-file write port and
// sequences LDB as BM_WORDS consecutive 16-bit reads assembled into one bitmap commit.
module wb_bitmap_loader #(
  parameter int BM_WORDS = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_reg_write,
  input  logic [3:0]               in_reg_addr,
  input  logic [15:0]              in_reg_data,
  input  logic                     in_ldb,
  input  logic [1:0]               in_bm_addr,
  input  logic [15:0]              in_mem_base,
  output logic                     mem_en,
  output logic [15:0]              mem_addr,
  input  logic [15:0]              mem_rdata,
  output logic                     write_reg_en,
  output logic [3:0]               write_reg_addr,
  output logic [15:0]              write_reg_data,
  output logic                     write_bm_en,
  output logic [1:0]               write_bm_addr,
  output logic [BM_WORDS*16-1:0]   write_bm_data,
  output logic                     stall
);

  localparam int IW = $clog2(BM_WORDS + 1);
  localparam logic [IW-1:0] ZERO_IDX = {IW{1'b0}};
  localparam logic [IW-1:0] ONE_IDX  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] LAST_IDX = IW'(BM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                  state_r;
  logic [IW-1:0]           i_r;
  logic                    mem_en_r;
  logic [15:0]             mem_addr_r;
  logic                    write_reg_en_r;
  logic [3:0]              write_reg_addr_r;
  logic [15:0]             write_reg_data_r;
  logic                    write_bm_en_r;
  logic [1:0]              write_bm_addr_r;
  logic [BM_WORDS*16-1:0]  write_bm_data_r;
  logic [IW-1:0]           word_idx_s;
  logic [IW+3:0]           bit_base_s;

  assign mem_en         = mem_en_r;
  assign mem_addr       = mem_addr_r;
  assign write_reg_en   = write_reg_en_r;
  assign write_reg_addr = write_reg_addr_r;
  assign write_reg_data = write_reg_data_r;
  assign write_bm_en    = write_bm_en_r;
  assign write_bm_addr  = write_bm_addr_r;
  assign write_bm_data  = write_bm_data_r;

  // Stall decode and the bit offset of the word arriving this cycle (read issued last cycle).
  always_comb begin
    stall      = 1'b0;
    word_idx_s = i_r - ONE_IDX;
    bit_base_s = {word_idx_s, 4'b0000};
    case (state_r)
      IDLE:    stall = in_valid && in_ldb;
      FETCH:   stall = 1'b1;
      DRAIN:   stall = 1'b1;
      COMMIT:  stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Control FSM with all outputs registered; COMMIT accepts a new instruction like IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      i_r              <= ZERO_IDX;
      mem_en_r         <= 1'b0;
      mem_addr_r       <= 16'h0000;
      write_reg_en_r   <= 1'b0;
      write_reg_addr_r <= 4'h0;
      write_reg_data_r <= 16'h0000;
      write_bm_en_r    <= 1'b0;
      write_bm_addr_r  <= 2'b00;
      write_bm_data_r  <= {(BM_WORDS*16){1'b0}};
    end else begin
      case (state_r)
        IDLE, COMMIT: begin
          write_bm_en_r <= 1'b0;
          if (in_valid && in_ldb) begin
            write_bm_addr_r <= in_bm_addr;
            mem_addr_r      <= in_mem_base;
            mem_en_r        <= 1'b1;
            i_r             <= ZERO_IDX;
            write_reg_en_r  <= 1'b0;
            state_r         <= FETCH;
          end else if (in_valid && in_reg_write) begin
            write_reg_en_r   <= 1'b1;
            write_reg_addr_r <= in_reg_addr;
            write_reg_data_r <= in_reg_data;
            state_r          <= IDLE;
          end else begin
            write_reg_en_r <= 1'b0;
            state_r        <= IDLE;
          end
        end
        FETCH: begin
          write_reg_en_r <= 1'b0;
          if (i_r != ZERO_IDX) begin
            write_bm_data_r[bit_base_s +: 16] <= mem_rdata;
          end else begin
            write_bm_data_r <= write_bm_data_r;
          end
          // The address counter wraps modulo 2^16 by its own width.
          if (i_r == LAST_IDX) begin
            mem_en_r   <= 1'b0;
            mem_addr_r <= 16'h0000;
            state_r    <= DRAIN;
          end else begin
            mem_addr_r <= mem_addr_r + 16'h0001;
            state_r    <= FETCH;
          end
          i_r <= i_r + ONE_IDX;
        end
        DRAIN: begin
          write_bm_data_r[bit_base_s +: 16] <= mem_rdata;
          write_bm_en_r <= 1'b1;
          i_r           <= ZERO_IDX;
          state_r       <= COMMIT;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bitmap_loader.sv
// Self-checking bench for wb_bitmap_loader: directed and randomized scenarios checked
// against a cycle-count / address-arithmetic reference model.
module tb_wb_bitmap_loader;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_reg_write, in_ldb;
  logic [3:0]    in_reg_addr;
  logic [15:0]   in_reg_data, in_mem_base;
  logic [1:0]    in_bm_addr;
  logic          mem_en;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_rdata = 16'h0000;
  logic          write_reg_en;
  logic [3:0]    write_reg_addr;
  logic [15:0]   write_reg_data;
  logic          write_bm_en;
  logic [1:0]    write_bm_addr;
  logic [1535:0] write_bm_data;
  logic          stall;

  int total = 0;
  int bad = 0;
  logic [15:0] key = 16'hA5A5;

  always #5 clk = ~clk;

  // Memory model: data = addr ^ key, one cycle after the read; garbage when not enabled.
  always @(posedge clk) mem_rdata <= mem_en ? (mem_addr ^ key) : 16'($urandom);

  wb_bitmap_loader #(.BM_WORDS(96)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_reg_addr(in_reg_addr), .in_reg_data(in_reg_data), .in_ldb(in_ldb),
    .in_bm_addr(in_bm_addr), .in_mem_base(in_mem_base), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .write_reg_en(write_reg_en),
    .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
    .write_bm_en(write_bm_en), .write_bm_addr(write_bm_addr),
    .write_bm_data(write_bm_data), .stall(stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; in_reg_write = 1'b0; in_ldb = 1'b0;
    in_reg_addr = 4'h0; in_reg_data = 16'h0000; in_bm_addr = 2'b00; in_mem_base = 16'h0000;
  endtask

  task automatic drive_write(input logic [3:0] a, input logic [15:0] d);
    in_valid = 1'b1; in_reg_write = 1'b1; in_ldb = 1'b0; in_reg_addr = a; in_reg_data = d;
  endtask

  task automatic drive_ldb(input logic [15:0] base, input logic [1:0] bm, input logic rw);
    in_valid = 1'b1; in_ldb = 1'b1; in_bm_addr = bm; in_mem_base = base;
    in_reg_write = rw; in_reg_addr = 4'($urandom); in_reg_data = 16'($urandom);
  endtask

  function automatic logic [1535:0] expected_bitmap(input logic [15:0] base, input logic [15:0] kk);
    logic [1535:0] bm;
    logic [15:0] a;
    bm = '0;
    for (int k = 0; k < 96; k++) begin
      a = base + 16'(k);
      bm[16*k +: 16] = a ^ kk;
    end
    return bm;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive_write(4'hF, 16'hFFFF);
    repeat (2) tick();
    #1;
    total++;
    if (stall !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 16'h0000) begin
      bad++; $display("FAIL reset_mem got stall=%b mem_en=%b mem_addr=%h exp 0/0/0000", stall, mem_en, mem_addr);
    end
    total++;
    if (write_reg_en !== 1'b0 || write_reg_addr !== 4'h0 || write_reg_data !== 16'h0000) begin
      bad++; $display("FAIL reset_reg got en=%b addr=%h data=%h exp zeros", write_reg_en, write_reg_addr, write_reg_data);
    end
    total++;
    if (write_bm_en !== 1'b0 || write_bm_addr !== 2'b00 || write_bm_data !== 1536'd0) begin
      bad++; $display("FAIL reset_bm got en=%b addr=%h data_nonzero=%b exp zeros", write_bm_en, write_bm_addr, |write_bm_data);
    end
    rst = 1'b0;
    drive_idle();
    tick();
  endtask

  task automatic test_scalar();
    logic [15:0] d1, d2;
    drive_write(4'h3, 16'hBEEF);
    tick();
    drive_idle();
    #1;
    total++;
    if (write_reg_en !== 1'b1 || write_reg_addr !== 4'h3 || write_reg_data !== 16'hBEEF) begin
      bad++; $display("FAIL scalar_n1 got en=%b addr=%h data=%h exp 1/3/beef", write_reg_en, write_reg_addr, write_reg_data);
    end
    tick();
    total++;
    if (write_reg_en !== 1'b0) begin
      bad++; $display("FAIL scalar_n2 got en=%b exp 0", write_reg_en);
    end
    d1 = 16'($urandom); d2 = 16'($urandom);
    drive_write(4'h1, d1);
    tick();
    drive_write(4'h2, d2);
    #1;
    total++;
    if (write_reg_en !== 1'b1 || write_reg_addr !== 4'h1 || write_reg_data !== d1) begin
      bad++; $display("FAIL b2b_first got en=%b addr=%h data=%h exp 1/1/%h", write_reg_en, write_reg_addr, write_reg_data, d1);
    end
    tick();
    drive_idle();
    #1;
    total++;
    if (write_reg_en !== 1'b1 || write_reg_addr !== 4'h2 || write_reg_data !== d2) begin
      bad++; $display("FAIL b2b_second got en=%b addr=%h data=%h exp 1/2/%h", write_reg_en, write_reg_addr, write_reg_data, d2);
    end
    tick();
    total++;
    if (write_reg_en !== 1'b0) begin
      bad++; $display("FAIL b2b_after got en=%b exp 0", write_reg_en);
    end
  endtask

  task automatic test_random_scalar();
    logic exp_en;
    logic [3:0] exp_a;
    logic [15:0] exp_d;
    for (int n = 0; n < 30; n++) begin
      in_valid = 1'($urandom); in_reg_write = 1'($urandom); in_ldb = 1'b0;
      in_reg_addr = 4'($urandom); in_reg_data = 16'($urandom);
      exp_en = in_valid && in_reg_write; exp_a = in_reg_addr; exp_d = in_reg_data;
      tick();
      total++;
      if (write_reg_en !== exp_en || (exp_en && (write_reg_addr !== exp_a || write_reg_data !== exp_d))) begin
        bad++; $display("FAIL rand_scalar n=%0d got en=%b addr=%h data=%h exp %b/%h/%h", n, write_reg_en, write_reg_addr, write_reg_data, exp_en, exp_a, exp_d);
      end
    end
    drive_idle();
    tick();
  endtask

  // One full LDB from acceptance (cycle A) to A+99, checking every cycle.
  task automatic test_ldb(input logic [15:0] base, input logic [1:0] bm, input logic [15:0] kk,
                          input logic with_rw, input logic repr);
    logic [1535:0] exp_bm;
    logic [15:0] exp_addr, d;
    logic exp_en;
    key = kk;
    exp_bm = expected_bitmap(base, kk);
    d = 16'($urandom);
    drive_ldb(base, bm, with_rw);
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL ldb_stall_accept got=%b exp=1", stall);
    end
    tick();
    for (int c = 1; c <= 98; c++) begin
      if (c == 98) begin
        if (repr) drive_write(4'h5, d); else drive_idle();
      end else begin
        drive_write(4'h5, d);
        in_ldb = 1'($urandom); in_bm_addr = 2'($urandom); in_mem_base = 16'($urandom);
      end
      #1;
      exp_en = (c <= 96);
      exp_addr = exp_en ? base + 16'(c - 1) : 16'h0000;
      total++;
      if (stall !== (c <= 97)) begin
        bad++; $display("FAIL ldb_stall c=%0d got=%b exp=%b", c, stall, (c <= 97));
      end
      total++;
      if (mem_en !== exp_en || mem_addr !== exp_addr) begin
        bad++; $display("FAIL ldb_mem c=%0d got en=%b addr=%h exp %b/%h", c, mem_en, mem_addr, exp_en, exp_addr);
      end
      total++;
      if (write_reg_en !== 1'b0) begin
        bad++; $display("FAIL ldb_reg_quiet c=%0d got=%b exp=0", c, write_reg_en);
      end
      total++;
      if (write_bm_en !== (c == 98)) begin
        bad++; $display("FAIL ldb_bm_en c=%0d got=%b exp=%b", c, write_bm_en, (c == 98));
      end
      if (c == 98) begin
        total++;
        if (write_bm_addr !== bm) begin
          bad++; $display("FAIL ldb_bm_addr got=%h exp=%h", write_bm_addr, bm);
        end
        total++;
        if (write_bm_data !== exp_bm) begin
          bad++;
          for (int k = 0; k < 96; k++) begin
            if (write_bm_data[16*k +: 16] !== exp_bm[16*k +: 16]) begin
              $display("FAIL ldb_bm_data word=%0d got=%h exp=%h", k, write_bm_data[16*k +: 16], exp_bm[16*k +: 16]);
              break;
            end
          end
        end
      end
      tick();
    end
    drive_idle();
    #1;
    total++;
    if (write_reg_en !== repr || (repr && (write_reg_addr !== 4'h5 || write_reg_data !== d))) begin
      bad++; $display("FAIL ldb_after_reg got en=%b addr=%h data=%h exp %b/5/%h", write_reg_en, write_reg_addr, write_reg_data, repr, d);
    end
    total++;
    if (write_bm_en !== 1'b0 || mem_en !== 1'b0 || write_bm_data !== exp_bm) begin
      bad++; $display("FAIL ldb_after_hold got bm_en=%b mem_en=%b data_ok=%b exp 0/0/1", write_bm_en, mem_en, write_bm_data === exp_bm);
    end
    tick();
  endtask

  task automatic test_wrap();
    test_ldb(16'hFFF0, 2'b01, 16'hA5A5, 1'b0, 1'b0);
    total++;
    if (write_bm_data[271:256] !== 16'hA5A5 || write_bm_data[255:240] !== 16'h5A5A) begin
      bad++; $display("FAIL wrap_words got w16=%h w15=%h exp a5a5/5a5a", write_bm_data[271:256], write_bm_data[255:240]);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [15:0] d;
    key = 16'h1234;
    drive_ldb(16'($urandom), 2'b11, 1'b0);
    tick();
    drive_idle();
    repeat (49) tick();
    rst = 1'b1;
    tick();
    #1;
    total++;
    if (mem_en !== 1'b0 || mem_addr !== 16'h0000 || stall !== 1'b0) begin
      bad++; $display("FAIL midrst_mem got mem_en=%b addr=%h stall=%b exp 0/0000/0", mem_en, mem_addr, stall);
    end
    total++;
    if (write_bm_en !== 1'b0 || write_bm_data !== 1536'd0) begin
      bad++; $display("FAIL midrst_bm got en=%b data_nonzero=%b exp 0/0", write_bm_en, |write_bm_data);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 110; n++) begin
      tick();
      if (write_bm_en === 1'b1 || stall === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL midrst_no_commit got activity=%b exp 0", seen);
    end
    d = 16'($urandom);
    drive_write(4'h7, d);
    tick();
    drive_idle();
    #1;
    total++;
    if (write_reg_en !== 1'b1 || write_reg_addr !== 4'h7 || write_reg_data !== d) begin
      bad++; $display("FAIL midrst_scalar got en=%b addr=%h data=%h exp 1/7/%h", write_reg_en, write_reg_addr, write_reg_data, d);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] b2;
    b2 = 16'($urandom);
    key = 16'($urandom);
    drive_ldb(16'($urandom), 2'b01, 1'b0);
    tick();
    drive_idle();
    repeat (97) tick();
    drive_ldb(b2, 2'b11, 1'b0);
    #1;
    total++;
    if (write_bm_en !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL b2b_ldb_commit got bm_en=%b stall=%b exp 1/0", write_bm_en, stall);
    end
    tick();
    drive_idle();
    #1;
    total++;
    if (mem_en !== 1'b1 || mem_addr !== b2 || write_bm_en !== 1'b0) begin
      bad++; $display("FAIL b2b_ldb_restart got mem_en=%b addr=%h bm_en=%b exp 1/%h/0", mem_en, mem_addr, write_bm_en, b2);
    end
    repeat (97) tick();
    total++;
    if (write_bm_en !== 1'b1 || write_bm_addr !== 2'b11 || write_bm_data !== expected_bitmap(b2, key)) begin
      bad++; $display("FAIL b2b_ldb_second got en=%b addr=%h data_ok=%b exp 1/3/1", write_bm_en, write_bm_addr, write_bm_data === expected_bitmap(b2, key));
    end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_scalar();
    test_ldb(16'h0100, 2'b10, 16'hA5A5, 1'b0, 1'b0);
    test_wrap();
    test_reset_mid();
    test_ldb(16'($urandom), 2'($urandom), 16'($urandom), 1'b1, 1'b1);
    test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      test_random_scalar();
      test_ldb(16'($urandom), 2'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
